// File: rtl/wb_regbank_responder.sv
// wb_regbank_responder
// Wishbone classic responder holding NUM_REGS read/write registers and a
// read-only status word at word address NUM_REGS. Each access is acknowledged
// after WAIT_STATES idle cycles with a single-cycle ACK.
// Optional build macro: WB_RESP_ERR_EN -- accesses above the status address
// answer with wb_ERR instead of wb_ACK.
`timescale 1ns/1ps

module wb_regbank_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 14,
  parameter int SEL_WIDTH     = 4,
  parameter int NUM_REGS      = 4,
  parameter int WAIT_STATES   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wb_CYC,
  input  logic                           wb_STB,
  input  logic                           wb_WE,
  input  logic [ADDRESS_WIDTH-1:0]       wb_ADR,
  input  logic [DATA_WIDTH-1:0]          wb_DAT_MOSI,
  input  logic [SEL_WIDTH-1:0]           wb_SEL,
  output logic [DATA_WIDTH-1:0]          wb_DAT_MISO,
  output logic                           wb_ACK,
  output logic                           wb_ERR,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] STATUS_ADR = ADDRESS_WIDTH'(NUM_REGS);
  localparam logic [3:0]               WAIT_INIT  = 4'(WAIT_STATES);

  state_t                   state_q, state_d;
  logic [3:0]               ctr_q, ctr_d;
  logic                     latch, commit;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] adr_q;
  logic [SEL_WIDTH-1:0]     sel_q;
  logic [DATA_WIDTH-1:0]    dat_q;
  logic                     eff_we;
  logic [ADDRESS_WIDTH-1:0] eff_adr;
  logic [SEL_WIDTH-1:0]     eff_sel;
  logic [DATA_WIDTH-1:0]    eff_dat;
  logic [DATA_WIDTH-1:0]    regs_r [NUM_REGS];
  logic [DATA_WIDTH-1:0]    rd_data;
  logic [DATA_WIDTH-1:0]    miso_q;
  logic [NUM_REGS-1:0]      pulse_q;

  // Next-state logic: decides when a request is taken, counted down and committed.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    latch   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_CYC && wb_STB) begin
          latch = 1'b1;
          ctr_d = WAIT_INIT;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb_CYC) begin
          state_d = IDLE;
          ctr_d   = 4'd0;
        end else begin
          ctr_d = ctr_q - 4'd1;
          if (ctr_q == 4'd1) begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      RESP: state_d = DONE;
      DONE: begin
        if (!wb_CYC || !wb_STB) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-wait commits happen on the request edge itself, so use the live bus then.
  always_comb begin
    if (state_q == IDLE) begin
      eff_we  = wb_WE;
      eff_adr = wb_ADR;
      eff_sel = wb_SEL;
      eff_dat = wb_DAT_MOSI;
    end else begin
      eff_we  = we_q;
      eff_adr = adr_q;
      eff_sel = sel_q;
      eff_dat = dat_q;
    end
  end

  // Read mux: registers, then status word; anything else reads as zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (eff_adr == ADDRESS_WIDTH'(k)) rd_data = regs_r[k];
    end
    if (eff_adr == STATUS_ADR) rd_data = status_in;
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // Capture the request so it survives the wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q  <= 1'b0;
      adr_q <= '0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (latch) begin
      we_q  <= wb_WE;
      adr_q <= wb_ADR;
      sel_q <= wb_SEL;
      dat_q <= wb_DAT_MOSI;
    end
  end

  // Register writes, write pulses and read data, all valid only for the response cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs_r[k] <= '0;
      miso_q  <= '0;
      pulse_q <= '0;
    end else begin
      miso_q  <= '0;
      pulse_q <= '0;
      if (commit) begin
        if (eff_we) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (eff_adr == ADDRESS_WIDTH'(k)) begin
              pulse_q[k] <= 1'b1;
              for (int b = 0; b < SEL_WIDTH; b++) begin
                if (eff_sel[b]) regs_r[k][b*8 +: 8] <= eff_dat[b*8 +: 8];
              end
            end
          end
        end else begin
          miso_q <= rd_data;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_q[k*DATA_WIDTH +: DATA_WIDTH] = regs_r[k];
  end

  assign wb_DAT_MISO = miso_q;
  assign wr_pulse    = pulse_q;

`ifdef WB_RESP_ERR_EN
  logic err_q;

  // Remember whether the committed access was above the status address.
  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (commit) err_q <= (eff_adr > STATUS_ADR);
  end

  assign wb_ACK = (state_q == RESP) && !err_q;
  assign wb_ERR = (state_q == RESP) &&  err_q;
`else
  assign wb_ACK = (state_q == RESP);
  assign wb_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_wb_regbank_responder.sv
// tb_wb_regbank_responder
// Drives one shared bus into two responders (0 and 3 wait states) and checks
// both every cycle against a transaction-level model, plus literal checks.
`timescale 1ns/1ps

module tb_wb_regbank_responder;

  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, stb, we;
  logic [13:0] adr;
  logic [31:0] mosi;
  logic [3:0]  sel;
  logic [31:0] status;

  logic [1:0]   ack_v, err_v;
  logic [31:0]  miso_v  [2];
  logic [127:0] regs_v  [2];
  logic [3:0]   pulse_v [2];

  int checks_total = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  wb_regbank_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .wb_CYC(cyc), .wb_STB(stb), .wb_WE(we),
    .wb_ADR(adr), .wb_DAT_MOSI(mosi), .wb_SEL(sel), .wb_DAT_MISO(miso_v[0]),
    .wb_ACK(ack_v[0]), .wb_ERR(err_v[0]), .status_in(status),
    .regs_q(regs_v[0]), .wr_pulse(pulse_v[0])
  );

  wb_regbank_responder #(.WAIT_STATES(WS1)) dut1 (
    .clk(clk), .reset(reset), .wb_CYC(cyc), .wb_STB(stb), .wb_WE(we),
    .wb_ADR(adr), .wb_DAT_MOSI(mosi), .wb_SEL(sel), .wb_DAT_MISO(miso_v[1]),
    .wb_ACK(ack_v[1]), .wb_ERR(err_v[1]), .status_in(status),
    .regs_q(regs_v[1]), .wr_pulse(pulse_v[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Transaction-level model: a request starts on an edge, commits WS edges later
  // if CYC stays up, answers for one cycle, then waits for STB to drop.
  int          edge_cnt = 0;
  logic        model_live = 1'b0;
  int          phase [2];
  int          start_edge [2];
  logic        t_we [2];
  logic [13:0] t_adr [2];
  logic [3:0]  t_sel [2];
  logic [31:0] t_dat [2];
  logic [31:0] mregs [2][4];
  logic        exp_ack [2];
  logic        exp_err [2];
  logic [31:0] exp_miso [2];
  logic [3:0]  exp_pulse [2];

  task automatic model_commit(input int i);
    logic out_of_range;
    out_of_range = (t_adr[i] > 14'd4);
    phase[i] = 2;
`ifdef WB_RESP_ERR_EN
    exp_err[i] = out_of_range;
    exp_ack[i] = !out_of_range;
`else
    exp_ack[i] = 1'b1;
`endif
    if (t_we[i]) begin
      if (t_adr[i] < 14'd4) begin
        for (int b = 0; b < 4; b++)
          if (t_sel[i][b]) mregs[i][t_adr[i]][b*8 +: 8] = t_dat[i][b*8 +: 8];
        exp_pulse[i] = 4'(1 << t_adr[i]);
      end
    end else begin
      if (t_adr[i] < 14'd4)       exp_miso[i] = mregs[i][t_adr[i]];
      else if (t_adr[i] == 14'd4) exp_miso[i] = status;
      else                        exp_miso[i] = 32'h0;
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    model_live = !reset;
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = 1'b0; exp_err[i] = 1'b0; exp_miso[i] = 32'h0; exp_pulse[i] = 4'h0;
      if (reset) begin
        phase[i] = 0;
        for (int k = 0; k < 4; k++) mregs[i][k] = 32'h0;
      end else begin
        case (phase[i])
          0: if (cyc && stb) begin
               t_we[i] = we; t_adr[i] = adr; t_sel[i] = sel; t_dat[i] = mosi;
               start_edge[i] = edge_cnt;
               if (i == 0) model_commit(i);
               else phase[i] = 1;
             end
          1: if (!cyc) phase[i] = 0;
             else if (edge_cnt - start_edge[i] == WS1) model_commit(i);
          2: phase[i] = 3;
          default: if (!cyc || !stb) phase[i] = 0;
        endcase
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("ack%0d", i), {31'h0, ack_v[i]}, {31'h0, exp_ack[i]});
        checkOutput($sformatf("err%0d", i), {31'h0, err_v[i]}, {31'h0, exp_err[i]});
        checkOutput($sformatf("miso%0d", i), miso_v[i], exp_miso[i]);
        checkOutput($sformatf("pulse%0d", i), {28'h0, pulse_v[i]}, {28'h0, exp_pulse[i]});
        for (int k = 0; k < 4; k++)
          checkOutput($sformatf("reg%0d_dut%0d", k, i), regs_v[i][k*32 +: 32], mregs[i][k]);
      end
    end
  end

  // Per-transaction observations for the literal checks.
  int          first_ack [2];
  int          ack_cnt [2];
  int          err_cnt [2];
  int          stray_miso [2];
  logic [31:0] cap_miso [2];
  logic [3:0]  cap_pulse [2];

  task automatic applyStimulus(input logic w, input logic [13:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int hold, input int abort_at,
                               input int gap);
    for (int i = 0; i < 2; i++) begin
      first_ack[i] = -1; ack_cnt[i] = 0; err_cnt[i] = 0; stray_miso[i] = 0;
      cap_miso[i] = 32'hxxxxxxxx; cap_pulse[i] = 4'h0;
    end
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; mosi = d; sel = w ? s : 4'h0;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ack_v[i]) begin
          ack_cnt[i]++;
          if (first_ack[i] < 0) first_ack[i] = c;
          cap_miso[i] = miso_v[i];
          cap_pulse[i] = pulse_v[i];
        end else if (miso_v[i] != 32'h0) begin
          stray_miso[i]++;
        end
        if (err_v[i]) err_cnt[i]++;
      end
      if (c == abort_at) break;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; mosi = '0; sel = '0; status = 32'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_ack", {31'h0, ack_v[i]}, 32'h0);
      checkOutput("rst_miso", miso_v[i], 32'h0);
      checkOutput("rst_pulse", {28'h0, pulse_v[i]}, 32'h0);
      checkOutput("rst_regs", regs_v[i][31:0] | regs_v[i][63:32] | regs_v[i][95:64] | regs_v[i][127:96], 32'h0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Full-word write, latency of both responders
    applyStimulus(1'b1, 14'd1, 32'hDEADBEEF, 4'hF, 6, 0, 2);
    checkOutput("lat_ws0", first_ack[0], 32'd1);
    checkOutput("lat_ws3", first_ack[1], 32'd4);
    for (int i = 0; i < 2; i++) begin
      checkOutput("t1_acks", ack_cnt[i], 32'd1);
      checkOutput("t1_pulse", {28'h0, cap_pulse[i]}, 32'h2);
      checkOutput("t1_reg1", regs_v[i][63:32], 32'hDEADBEEF);
    end

    // Byte-lane merge
    applyStimulus(1'b1, 14'd0, 32'h11223344, 4'hF, 6, 0, 2);
    applyStimulus(1'b1, 14'd0, 32'hAABBCCDD, 4'b0101, 6, 0, 2);
    applyStimulus(1'b0, 14'd0, 32'h0, 4'h0, 6, 0, 2);
    for (int i = 0; i < 2; i++) begin
      checkOutput("t2_reg0", regs_v[i][31:0], 32'h11BB33DD);
      checkOutput("t2_read", cap_miso[i], 32'h11BB33DD);
    end

    // Read with wait states, data only during ACK
    applyStimulus(1'b1, 14'd2, 32'h5A5A0002, 4'hF, 6, 0, 2);
    applyStimulus(1'b0, 14'd2, 32'h0, 4'h0, 7, 0, 2);
    checkOutput("t3_lat", first_ack[1], 32'd4);
    checkOutput("t3_acks", ack_cnt[1], 32'd1);
    for (int i = 0; i < 2; i++) begin
      checkOutput("t3_read", cap_miso[i], 32'h5A5A0002);
      checkOutput("t3_stray", stray_miso[i], 32'd0);
    end

    // Status word read, write to it ignored
    status = 32'hCAFE0001;
    applyStimulus(1'b0, 14'd4, 32'h0, 4'h0, 6, 0, 2);
    for (int i = 0; i < 2; i++) checkOutput("t4_status", cap_miso[i], 32'hCAFE0001);
    applyStimulus(1'b1, 14'd4, 32'h12345678, 4'hF, 6, 0, 2);
    for (int i = 0; i < 2; i++) begin
      checkOutput("t4_wack", ack_cnt[i], 32'd1);
      checkOutput("t4_pulse", {28'h0, cap_pulse[i]}, 32'h0);
      checkOutput("t4_reg0", regs_v[i][31:0], 32'h11BB33DD);
      checkOutput("t4_reg3", regs_v[i][127:96], 32'h0);
    end

    // Out-of-range read
    applyStimulus(1'b0, 14'd9, 32'h0, 4'h0, 6, 0, 2);
    for (int i = 0; i < 2; i++) begin
`ifdef WB_RESP_ERR_EN
      checkOutput("t5_err", err_cnt[i], 32'd1);
      checkOutput("t5_ack", ack_cnt[i], 32'd0);
`else
      checkOutput("t5_ack", ack_cnt[i], 32'd1);
      checkOutput("t5_data", cap_miso[i], 32'h0);
      checkOutput("t5_err", err_cnt[i], 32'd0);
`endif
    end

    // CYC dropped in the middle of the wait, then a long-held STB
    applyStimulus(1'b1, 14'd3, 32'h0F0F0F0F, 4'hF, 8, 2, 3);
    checkOutput("t6_abort_ack", ack_cnt[1], 32'd0);
    checkOutput("t6_abort_reg", regs_v[1][127:96], 32'h0);
    checkOutput("t6_ws0_reg", regs_v[0][127:96], 32'h0F0F0F0F);
    applyStimulus(1'b0, 14'd1, 32'h0, 4'h0, 10, 0, 2);
    for (int i = 0; i < 2; i++) checkOutput("t6_single_ack", ack_cnt[i], 32'd1);

    // Randomised traffic against the model
    for (int n = 0; n < 200; n++) begin
      logic        rw;
      logic [13:0] ra;
      int          ab;
      rw = 1'($urandom_range(0, 1));
      ra = 14'($urandom_range(0, 9));
      status = $urandom;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      applyStimulus(rw, ra, $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(4, 8)), ab, int'($urandom_range(1, 3)));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
